// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the fetch stage and its pipeline registers
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_e;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register with squash (to bubble), load and hold; squash beats load
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   squash,
  input  if_id_t d,
  output if_id_t q
);
  localparam if_id_t BUBBLE = '{instr: NOP, pc_plus4: 32'h0, valid: 1'b0};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= BUBBLE;
    else if (squash) q <= BUBBLE;
    else if (load) q <= d;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: MIPS IF stage owning the PC, applying stall/flush/redirects,
// and halting with a sticky fault on a misaligned or out-of-range PC
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] pc,
  output logic        fetch_fault
);
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);
  fetch_state_e state;
  logic [31:0] pc_plus4, target, pc_next;
  logic run, bad_pc, redirect, squash, load;
  if_id_t if_id_d, if_id_q;
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign run       = state == RUN;
  assign bad_pc    = (pc[1:0] != 2'b00) || (pc >= PC_LIMIT);
  assign redirect  = branch_taken || jump;
  // branch_taken belongs to the older instruction, so it wins over jump
  assign target    = branch_taken ? branch_target : jump_target;
  assign squash    = (state == BOOT) || (run && (bad_pc || redirect || flush));
  assign load      = run && !bad_pc && !redirect && !flush && !stall;
  assign pc_next   = (!run || bad_pc) ? pc : redirect ? target : stall ? pc : pc_plus4;
  assign if_id_d   = '{instr: imem_data, pc_plus4: pc_plus4, valid: 1'b1};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
    end else begin
      pc <= pc_next;
      if (state == BOOT) state <= RUN;
      else if (run && bad_pc) begin
        state       <= HALT;
        fetch_fault <= 1'b1;
      end
    end
  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .squash (squash),
    .d      (if_id_d),
    .q      (if_id_q)
  );
  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_valid    = if_id_q.valid;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed vectors against hand-computed expectations
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n, stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target, imem_addr, imem_data;
  logic [31:0] if_id_instr, if_id_pc_plus4, pc;
  logic        if_id_valid, fetch_fault;
  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // instruction memory: word i holds 32'h02108020 + i
  assign imem_data = 32'h0210_8020 + (imem_addr >> 2);

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .pc             (pc),
    .fetch_fault    (fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                         input logic [31:0] e_pp4, input logic e_valid, input logic e_fault);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".addr"}, imem_addr, e_pc);
    chk({tag, ".instr"}, if_id_instr, e_instr);
    chk({tag, ".pc_plus4"}, if_id_pc_plus4, e_pp4);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, e_valid});
    chk({tag, ".fault"}, {31'b0, fetch_fault}, {31'b0, e_fault});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    #12;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 0, 0);
    tick();
    rst_n = 1;
    tick();
    chk_all("boot", 32'h0, 32'h0, 32'h0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_all("seq", 32'(4 * (k + 1)), 32'h0210_8020 + 32'(k), 32'(4 * (k + 1)), 1, 0);
    end
    jump = 1; jump_target = 32'h4;
    tick();
    idle();
    chk_all("jmp4", 32'h4, 32'h0, 32'h0, 0, 0);
    tick();
    chk_all("fetch1", 32'h8, 32'h0210_8021, 32'h8, 1, 0);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("stall", 32'h8, 32'h0210_8021, 32'h8, 1, 0);
    end
    stall = 0;
    tick();
    chk_all("unstall", 32'hC, 32'h0210_8022, 32'hC, 1, 0);
    branch_taken = 1; branch_target = 32'h40; stall = 1;
    tick();
    idle();
    chk_all("br_over_stall", 32'h40, 32'h0, 32'h0, 0, 0);
    tick();
    chk_all("br_fetch", 32'h44, 32'h0210_8030, 32'h44, 1, 0);
    branch_taken = 1; branch_target = 32'h20; jump = 1; jump_target = 32'h80;
    tick();
    idle();
    chk_all("br_beats_jmp", 32'h20, 32'h0, 32'h0, 0, 0);
    jump = 1; jump_target = 32'hC;
    tick();
    idle();
    tick();
    chk_all("fetch3", 32'h10, 32'h0210_8023, 32'h10, 1, 0);
    flush = 1;
    tick();
    chk_all("flush", 32'h14, 32'h0, 32'h0, 0, 0);
    stall = 1;
    tick();
    idle();
    chk_all("flush_stall", 32'h14, 32'h0, 32'h0, 0, 0);
    jump = 1; jump_target = 32'h6;
    tick();
    idle();
    chk_all("jmp_mis", 32'h6, 32'h0, 32'h0, 0, 0);
    tick();
    chk_all("fault", 32'h6, 32'h0, 32'h0, 0, 1);
    branch_taken = 1; branch_target = 32'h40; jump = 1; jump_target = 32'h80;
    tick();
    tick();
    chk_all("halt_frozen", 32'h6, 32'h0, 32'h0, 0, 1);
    #2 rst_n = 0;
    #1 chk_all("async_reset", 32'h0, 32'h0, 32'h0, 0, 0);
    idle();
    jump = 1; jump_target = 32'h40;
    tick();
    rst_n = 1;
    tick();
    idle();
    chk_all("boot_ignores", 32'h0, 32'h0, 32'h0, 0, 0);
    tick();
    chk_all("after_boot", 32'h4, 32'h0210_8020, 32'h4, 1, 0);
    jump = 1; jump_target = 32'hFF8;
    tick();
    idle();
    chk_all("jmp_ff8", 32'hFF8, 32'h0, 32'h0, 0, 0);
    tick();
    chk_all("word1022", 32'hFFC, 32'h0210_841E, 32'hFFC, 1, 0);
    tick();
    chk_all("word1023", 32'h1000, 32'h0210_841F, 32'h1000, 1, 0);
    tick();
    chk_all("oob_fault", 32'h1000, 32'h0, 32'h0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction memory read address, and captures the returned word into the IF/ID pipeline register.
- Applies stall and flush from the hazard unit and branch/jump redirects from EX/ID.
- Halts with a fault flag when the PC is misaligned or leaves instruction memory.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words (4 KB); legal PCs are 0 .. IMEM_WORDS*4-4.
- NOP_INSTR, 32'h00000000, bubble word (sll $0,$0,0) written into IF/ID on squash.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  hazard unit: squash IF/ID to a bubble.
- branch_taken  in  1  EX stage: taken branch.
- branch_target  in  32  branch destination byte address.
- jump  in  1  ID stage: j/jal decoded.
- jump_target  in  32  jump destination byte address.
- imem_addr  out  32  byte address to instruction memory (word index = addr>>2).
- imem_data  in  32  instruction word, combinational from imem_addr.
- if_id_instr  out  32  registered instruction to decode.
- if_id_pc_plus4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  1 = IF/ID holds a real instruction.
- pc  out  32  current PC (debug).
- fetch_fault  out  1  sticky: fetch halted on a bad PC.

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC; if_id_instr=NOP_INSTR; if_id_pc_plus4=0; if_id_valid=0; fetch_fault=0; state=BOOT.
  - Reset asserted mid-operation discards all in-flight state immediately.
- imem_addr = pc, combinational from the PC register; no extra latency. An instruction fetched at edge N is visible on if_id_* after edge N.
- pc_plus4 = pc + 4, 32-bit, wraps modulo 2^32. The wrap is unreachable while pc is in range.
- States:
  - BOOT: lasts exactly one edge after reset release. IF/ID stays a bubble, pc holds RESET_PC, next state RUN.
  - RUN: normal fetch; per-edge actions below.
  - HALT: pc, IF/ID (bubble, valid=0) and fetch_fault=1 are frozen. Exit only via reset.
- RUN per-edge priority, highest first:
  1. Bad PC: pc[1:0]!=0 or pc>=IMEM_WORDS*4. Go to HALT, set fetch_fault=1, write IF/ID bubble, pc unchanged.
  2. Redirect (branch_taken or jump; branch_taken wins if both, being the older instruction).
     - pc <= selected target; IF/ID <= bubble.
     - Overrides stall and flush.
     - A misaligned or out-of-range target is accepted into pc and faults on the next edge via rule 1.
  3. flush: IF/ID <= bubble. pc <= pc+4 if stall=0, else pc holds.
  4. stall: pc and all IF/ID fields hold.
  5. Otherwise: if_id_instr <= imem_data; if_id_pc_plus4 <= pc+4; if_id_valid <= 1; pc <= pc+4.
- Bubble definition: if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0.
- Inputs are ignored in BOOT and HALT.
- Last legal word (pc=IMEM_WORDS*4-4): fetched normally; the next edge faults.

Decomposition:
- Shared package fetch_pkg holds:
  - the NOP_INSTR constant;
  - the fetch state enum (BOOT, RUN, HALT);
  - the IF/ID bundle struct (instr, pc_plus4, valid);
  - a default RESET_PC constant.
- One sub-module, if_id_reg: the pipeline register with load/hold/squash controls and async active-low reset. It is reused later for the other pipeline registers.
- PC, FSM and priority logic stay in instruction_fetch_unit.

Test Plan:
- Reset release, memory word i = 32'h02108020 + i, no stall → edge 1 valid=0 (BOOT). Edges 2..9 give if_id_instr 02108020, 02108021, … with pc_plus4 4, 8, …, 32, valid=1.
- stall held 3 edges at pc=8 → pc stays 8 and IF/ID unchanged for 3 edges. Release → instr for pc=8 captured next edge.
- branch_taken=1, branch_target=32'h40, with stall=1 simultaneously → next edge pc=0x40, IF/ID bubble. Following edge captures word 16, pc_plus4=0x44.
- branch_taken and jump both high with targets 0x20 and 0x80 → pc=0x20. Flush alone at pc=0x10 → IF/ID bubble, pc=0x14.
- jump_target=32'h0000_0006 → pc=6, then fetch_fault=1, state HALT, valid=0. Later stimulus has no effect until rst_n pulses low, which restores pc=0 and fault=0 asynchronously.
- Run to pc=0xFFC → word 1023 fetched. Next edge pc=0x1000 faults, fetch_fault=1, if_id_valid=0.
